// File: rtl/tlm_batch_sched.sv
// Ping-pong batch scheduler: requests NUM-pair batches from the host, buffers them in two banks
// and streams one {A,B} pair per cycle to the operand bfm until MAX_BATCHES have been issued.
module tlm_batch_sched #(
    parameter int unsigned NUM         = 16,
    parameter int unsigned ITEM_WIDTH  = 8,
    parameter int unsigned MAX_BATCHES = 2000
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    start_i,
    output logic                    batch_req_o,
    input  logic                    wr_valid_i,
    output logic                    wr_ready_o,
    input  logic [2*ITEM_WIDTH-1:0] wr_data_i,
    input  logic                    stall_i,
    output logic [ITEM_WIDTH-1:0]   a_o,
    output logic [ITEM_WIDTH-1:0]   b_o,
    output logic                    xmit_o,
    output logic                    batch_done_o,
    output logic [31:0]             batch_cnt_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int unsigned    IdxW    = $clog2(NUM);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM - 1);
    localparam logic [31:0]    MaxCnt  = 32'(MAX_BATCHES);

    typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;
    typedef enum logic [1:0] {BkEmpty, BkFilling, BkFull, BkDraining} bank_e;

    state_e                  state_q, state_d;
    bank_e                   bank_q [2];
    bank_e                   bank_d [2];
    logic [1:0]              pend_q, pend_d;
    logic                    fill_q, fill_d;
    logic                    drain_q, drain_d;
    logic [IdxW-1:0]         wr_idx_q, wr_idx_d;
    logic [IdxW-1:0]         rd_idx_q, rd_idx_d;
    logic [31:0]             req_cnt_q, req_cnt_d;
    logic [31:0]             batch_cnt_q, batch_cnt_d;
    logic [ITEM_WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic                    xmit_q, xmit_d;
    logic                    bdone_q, bdone_d;
    logic [2*ITEM_WIDTH-1:0] mem_q [2][NUM];

    logic                    run, enter_run, req_ok, req_fire, req_bank;
    logic [1:0]              can_req, granted;
    logic                    wr_ready, wr_fire, fill_last;
    logic                    rd_ok, rd_last;
    logic [2*ITEM_WIDTH-1:0] rd_word;

    assign run       = (state_q == StRun);
    assign enter_run = start_i && (state_q != StRun);
    assign req_ok    = run && ((MaxCnt == 32'd0) || (req_cnt_q < MaxCnt));

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            can_req[i] = (bank_q[i] == BkEmpty) && !pend_q[i];
        end
    end

    // Prefer the bank the host will write next so a late request never blocks the fill pointer.
    assign req_bank  = can_req[fill_q] ? fill_q : !fill_q;
    assign req_fire  = req_ok && (can_req != 2'b00);
    assign granted   = pend_q | (req_fire ? (2'b01 << req_bank) : 2'b00);
    assign wr_ready  = run && granted[fill_q];
    assign wr_fire   = wr_valid_i && wr_ready;
    assign fill_last = wr_fire && (wr_idx_q == LastIdx);

    assign rd_ok   = run && !stall_i &&
                     ((bank_q[drain_q] == BkFull) || (bank_q[drain_q] == BkDraining));
    assign rd_last = rd_ok && (rd_idx_q == LastIdx);
    assign rd_word = mem_q[drain_q][rd_idx_q];

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start_i) state_d = StRun;
            StRun:    if ((MaxCnt != 32'd0) && (batch_cnt_q == MaxCnt)) state_d = StFinish;
            StFinish: if (start_i) state_d = StRun;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        batch_req_o  = req_fire;
        wr_ready_o   = wr_ready;
        busy_o       = run;
        done_o       = (state_q == StFinish);
        a_o          = a_q;
        b_o          = b_q;
        xmit_o       = xmit_q;
        batch_done_o = bdone_q;
        batch_cnt_o  = batch_cnt_q;
    end

    always_comb begin
        bank_d      = bank_q;
        pend_d      = pend_q;
        fill_d      = fill_q;
        drain_d     = drain_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        req_cnt_d   = req_cnt_q;
        batch_cnt_d = batch_cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        xmit_d      = 1'b0;
        bdone_d     = 1'b0;
        if (enter_run) begin
            bank_d[0]   = BkEmpty;
            bank_d[1]   = BkEmpty;
            pend_d      = 2'b00;
            fill_d      = 1'b0;
            drain_d     = 1'b0;
            wr_idx_d    = '0;
            rd_idx_d    = '0;
            req_cnt_d   = 32'd0;
            batch_cnt_d = 32'd0;
        end else begin
            if (req_fire) begin
                pend_d[req_bank] = 1'b1;
                req_cnt_d        = req_cnt_q + 32'd1;
            end
            if (wr_fire) begin
                if (fill_last) begin
                    bank_d[fill_q] = BkFull;
                    pend_d[fill_q] = 1'b0;
                    fill_d         = !fill_q;
                    wr_idx_d       = '0;
                end else begin
                    bank_d[fill_q] = BkFilling;
                    wr_idx_d       = wr_idx_q + 1'b1;
                end
            end
            // Fill and drain always target different banks, so both updates can land together.
            if (rd_ok) begin
                a_d    = rd_word[ITEM_WIDTH-1:0];
                b_d    = rd_word[2*ITEM_WIDTH-1:ITEM_WIDTH];
                xmit_d = 1'b1;
                if (rd_last) begin
                    bank_d[drain_q] = BkEmpty;
                    drain_d         = !drain_q;
                    rd_idx_d        = '0;
                    bdone_d         = 1'b1;
                    batch_cnt_d     = batch_cnt_q + 32'd1;
                end else begin
                    bank_d[drain_q] = BkDraining;
                    rd_idx_d        = rd_idx_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            bank_q[0]   <= BkEmpty;
            bank_q[1]   <= BkEmpty;
            pend_q      <= 2'b00;
            fill_q      <= 1'b0;
            drain_q     <= 1'b0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            req_cnt_q   <= 32'd0;
            batch_cnt_q <= 32'd0;
            a_q         <= '0;
            b_q         <= '0;
            xmit_q      <= 1'b0;
            bdone_q     <= 1'b0;
        end else begin
            bank_q      <= bank_d;
            pend_q      <= pend_d;
            fill_q      <= fill_d;
            drain_q     <= drain_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            req_cnt_q   <= req_cnt_d;
            batch_cnt_q <= batch_cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            xmit_q      <= xmit_d;
            bdone_q     <= bdone_d;
        end
    end

    // Bank contents carry no reset; bank state alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem_q[fill_q][wr_idx_q] <= wr_data_i;
        end
    end

endmodule

// File: tb/tb_tlm_batch_sched.sv
// Scoreboard bench for tlm_batch_sched: one instance with MAX_BATCHES=1, one with MAX_BATCHES=3.
module tb_tlm_batch_sched;

    localparam int unsigned NUM = 4;
    localparam int unsigned W   = 8;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         last;
    } exp_t;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    logic          rst1_n, rst3_n, start, host_en, stall, sel;
    logic [2*W-1:0] wr_data;

    logic         req1, rdy1, x1, bd1, busy1, fin1;
    logic [W-1:0] a1, b1;
    logic [31:0]  cnt1;
    logic         req3, rdy3, x3, bd3, busy3, fin3;
    logic [W-1:0] a3, b3;
    logic [31:0]  cnt3;

    tlm_batch_sched #(.NUM(NUM), .ITEM_WIDTH(W), .MAX_BATCHES(1)) u_dut1 (
        .clk_i(clk), .reset_ni(rst1_n), .start_i(start), .batch_req_o(req1),
        .wr_valid_i(host_en), .wr_ready_o(rdy1), .wr_data_i(wr_data), .stall_i(stall),
        .a_o(a1), .b_o(b1), .xmit_o(x1), .batch_done_o(bd1), .batch_cnt_o(cnt1),
        .busy_o(busy1), .done_o(fin1)
    );

    tlm_batch_sched #(.NUM(NUM), .ITEM_WIDTH(W), .MAX_BATCHES(3)) u_dut3 (
        .clk_i(clk), .reset_ni(rst3_n), .start_i(start), .batch_req_o(req3),
        .wr_valid_i(host_en), .wr_ready_o(rdy3), .wr_data_i(wr_data), .stall_i(stall),
        .a_o(a3), .b_o(b3), .xmit_o(x3), .batch_done_o(bd3), .batch_cnt_o(cnt3),
        .busy_o(busy3), .done_o(fin3)
    );

    logic         m_req, m_rdy, m_x, m_bd, m_busy, m_fin, m_rst;
    logic [W-1:0] m_a, m_b;
    logic [31:0]  m_cnt;
    assign m_req  = sel ? req3  : req1;
    assign m_rdy  = sel ? rdy3  : rdy1;
    assign m_x    = sel ? x3    : x1;
    assign m_bd   = sel ? bd3   : bd1;
    assign m_busy = sel ? busy3 : busy1;
    assign m_fin  = sel ? fin3  : fin1;
    assign m_a    = sel ? a3    : a1;
    assign m_b    = sel ? b3    : b1;
    assign m_cnt  = sel ? cnt3  : cnt1;
    assign m_rst  = sel ? rst3_n : rst1_n;

    exp_t        sb [$];
    int unsigned n_chk = 0, n_fail = 0;
    int unsigned beat_k = 0, run_beat = 0;
    int unsigned xmit_cnt = 0, req_cnt = 0, run_len = 0, max_run = 0;
    logic [W-1:0] last_a = '0, last_b = '0;
    logic        mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Host: always offers the next pair; pair k is (2k+1, 2k+2).
    initial begin
        logic acc;
        exp_t e;
        forever begin
            @(negedge clk);
            acc = host_en && m_rdy && m_rst;
            @(posedge clk);
            #1;
            if (acc) begin
                e.a    = wr_data[W-1:0];
                e.b    = wr_data[2*W-1:W];
                e.last = ((run_beat % NUM) == NUM - 1);
                sb.push_back(e);
                run_beat++;
                beat_k++;
                wr_data = {W'(2 * beat_k + 2), W'(2 * beat_k + 1)};
            end
        end
    end

    // Monitor: every xmit pops one expected pair; idle cycles must hold the last pair.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (m_req) req_cnt++;
                if (m_x) begin
                    xmit_cnt++;
                    run_len++;
                    if (run_len > max_run) max_run = run_len;
                    if (sb.size() == 0) begin
                        chk("xmit with empty scoreboard", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("a_o", 32'(m_a), 32'(e.a));
                        chk("b_o", 32'(m_b), 32'(e.b));
                        chk("batch_done_o", 32'(m_bd), 32'(e.last));
                        last_a = e.a;
                        last_b = e.b;
                    end
                end else begin
                    run_len = 0;
                    chk("a_o hold", 32'(m_a), 32'(last_a));
                    chk("b_o hold", 32'(m_b), 32'(last_b));
                    chk("batch_done_o idle", 32'(m_bd), 32'd0);
                end
            end
        end
    end

    task automatic clr_stats();
        xmit_cnt = 0;
        req_cnt  = 0;
        max_run  = 0;
        run_beat = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_fin(input int unsigned bound, input string name);
        int unsigned n = 0;
        while (!m_fin && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(m_fin), 32'd1);
    endtask

    task automatic chk_idle(input string tag);
        @(negedge clk);
        chk({tag, " busy_o"}, 32'(m_busy), 32'd0);
        chk({tag, " done_o"}, 32'(m_fin), 32'd0);
        chk({tag, " xmit_o"}, 32'(m_x), 32'd0);
        chk({tag, " batch_req_o"}, 32'(m_req), 32'd0);
        chk({tag, " wr_ready_o"}, 32'(m_rdy), 32'd0);
        chk({tag, " a_o"}, 32'(m_a), 32'd0);
        chk({tag, " b_o"}, 32'(m_b), 32'd0);
        chk({tag, " batch_cnt_o"}, m_cnt, 32'd0);
    endtask

    initial begin
        int unsigned n;
        rst1_n  = 1'b0;
        rst3_n  = 1'b0;
        start   = 1'b0;
        host_en = 1'b0;
        stall   = 1'b0;
        sel     = 1'b0;
        wr_data = {W'(2), W'(1)};
        repeat (2) @(posedge clk);
        #1 rst1_n = 1'b1;

        // MAX_BATCHES=1: pairs (1,2)..(7,8), then FINISH with one batch
        chk_idle("reset1");
        mon_en  = 1'b1;
        clr_stats();
        host_en = 1'b1;
        pulse_start();
        wait_fin(100, "max1 finish");
        chk("max1 batch_cnt_o", m_cnt, 32'd1);
        chk("max1 xmit count", xmit_cnt, 32'd4);
        chk("max1 request count", req_cnt, 32'd1);
        chk("max1 beats accepted", run_beat, 32'd4);
        chk("max1 last a_o", 32'(m_a), 32'd7);
        chk("max1 wr_ready_o in FINISH", 32'(m_rdy), 32'd0);
        chk("max1 busy_o in FINISH", 32'(m_busy), 32'd0);

        // MAX_BATCHES=3 with an always-ready host: 12 back-to-back pairs
        @(posedge clk); #1;
        host_en = 1'b0;
        sel     = 1'b1;
        rst1_n  = 1'b0;
        rst3_n  = 1'b1;
        last_a  = '0;
        last_b  = '0;
        chk_idle("reset3");
        clr_stats();
        host_en = 1'b1;
        pulse_start();
        wait_fin(200, "max3 finish");
        chk("max3 batch_cnt_o", m_cnt, 32'd3);
        chk("max3 xmit count", xmit_cnt, 32'd12);
        chk("max3 longest xmit run", max_run, 32'd12);
        chk("max3 request count", req_cnt, 32'd3);
        chk("max3 scoreboard drained", sb.size(), 32'd0);

        // Restart from FINISH, stall 3 cycles mid-batch, ignored start during RUN
        clr_stats();
        pulse_start();
        @(negedge clk);
        chk("restart busy_o", 32'(m_busy), 32'd1);
        chk("restart batch_cnt_o", m_cnt, 32'd0);
        chk("restart done_o", 32'(m_fin), 32'd0);
        n = 0;
        while (!m_x && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("first xmit seen", 32'(m_x), 32'd1);
        @(posedge clk); #1;
        stall = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("xmit_o during stall", 32'(m_x), 32'd0);
        end
        stall = 1'b0;
        pulse_start();
        @(negedge clk);
        chk("start in RUN keeps busy_o", 32'(m_busy), 32'd1);
        wait_fin(200, "stall run finish");
        chk("stall run xmit count", xmit_cnt, 32'd12);
        chk("stall run batch_cnt_o", m_cnt, 32'd3);
        chk("stall run request count", req_cnt, 32'd3);

        // Both banks full while stalled: no further beats, no extra requests
        clr_stats();
        stall = 1'b1;
        pulse_start();
        repeat (20) @(negedge clk);
        chk("both full wr_ready_o", 32'(m_rdy), 32'd0);
        chk("both full request count", req_cnt, 32'd2);
        chk("both full beats accepted", run_beat, 32'd8);
        chk("both full xmit count", xmit_cnt, 32'd0);
        @(posedge clk); #1;
        stall = 1'b0;
        wait_fin(200, "both full finish");
        chk("both full total xmit", xmit_cnt, 32'd12);

        // Reset after two beats of bank 1, then restart with fresh data only
        clr_stats();
        pulse_start();
        n = 0;
        while (run_beat < 6 && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        chk("beats before reset", run_beat, 32'd6);
        rst3_n  = 1'b0;
        host_en = 1'b0;
        @(posedge clk); #2;
        sb.delete();
        last_a = '0;
        last_b = '0;
        chk_idle("mid-run reset");
        @(posedge clk); #1;
        rst3_n = 1'b1;
        clr_stats();
        host_en = 1'b1;
        pulse_start();
        wait_fin(200, "post-reset finish");
        chk("post-reset xmit count", xmit_cnt, 32'd12);
        chk("post-reset batch_cnt_o", m_cnt, 32'd3);
        chk("post-reset scoreboard drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
